// File: rtl/ipsl_ddrphy_rst_req_gen.sv
// DDR PHY DQS reset-training initiator: start pulse -> level req held until ack; timeout/retry/err under DDRPHY_RST_REQ_TIMEOUT_EN.
// Latency: req rises 1 cycle after an accepted start (gap expired); done/req-fall 1 cycle after ack.
// No backpressure: starts arriving before service merge into one pending request.
module ipsl_ddrphy_rst_req_gen #(
  parameter int unsigned TIMEOUT_CLK = 64,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned REQ_LOW_CLK = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_start,
  input  logic       ddrphy_rst_ack,
  output logic       ddrphy_rst_req,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] retry_cnt
);

  if (REQ_LOW_CLK < 3 || REQ_LOW_CLK > 15 || TIMEOUT_CLK < 16 || TIMEOUT_CLK > 255 ||
      MAX_RETRY > 7) begin : g_param_chk
    $error("ipsl_ddrphy_rst_req_gen: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(REQ_LOW_CLK);

  state_t     state_q, state_d;
  logic       ret_req_q, ret_req_d;
  logic [3:0] gap_q, gap_d;
  logic       pend_q, pend_d;
  logic       req_q, req_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;

`ifdef DDRPHY_RST_REQ_TIMEOUT_EN
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CLK - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  logic [7:0] to_q, to_d;
  logic [2:0] retry_q, retry_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    ret_req_d = ret_req_q;
    pend_d    = pend_q | req_start;
    req_d     = 1'b0;
    done_d    = 1'b0;
`ifdef DDRPHY_RST_REQ_TIMEOUT_EN
    to_d      = to_q;
    retry_d   = retry_q;
    err_d     = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pend_d && (gap_q == 4'd0)) begin
          pend_d  = 1'b0;
          state_d = ST_REQ;
          req_d   = 1'b1;
`ifdef DDRPHY_RST_REQ_TIMEOUT_EN
          to_d    = 8'd0;
          retry_d = 3'd0;
          err_d   = 1'b0;
`endif
        end
      end
      ST_REQ: begin
        // ack takes priority over a coincident timeout
        if (ddrphy_rst_ack) begin
          done_d    = 1'b1;
          state_d   = ST_GAP;
          ret_req_d = 1'b0;
        end
`ifdef DDRPHY_RST_REQ_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          state_d = ST_GAP;
          if (retry_q != RETRY_MAX) begin
            retry_d   = retry_q + 3'd1;
            ret_req_d = 1'b1;
          end else begin
            err_d     = 1'b1;
            ret_req_d = 1'b0;
          end
        end else begin
          req_d = 1'b1;
          to_d  = to_q + 8'd1;
        end
`else
        else begin
          req_d = 1'b1;
        end
`endif
      end
      ST_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = ret_req_q ? ST_REQ : ST_IDLE;
          req_d   = ret_req_q;
`ifdef DDRPHY_RST_REQ_TIMEOUT_EN
          to_d    = 8'd0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // low-time counter: reload on the falling edge, count down while low
    if (req_q && !req_d) begin
      gap_d = GAP_LOAD;
    end else if (!req_q && (gap_q != 4'd0)) begin
      gap_d = gap_q - 4'd1;
    end else begin
      gap_d = gap_q;
    end

    busy_d = (state_d != ST_IDLE) || pend_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      ret_req_q <= 1'b0;
      gap_q     <= GAP_LOAD;
      pend_q    <= 1'b0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_req_q <= ret_req_d;
      gap_q     <= gap_d;
      pend_q    <= pend_d;
      req_q     <= req_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

`ifdef DDRPHY_RST_REQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_q    <= 8'd0;
      retry_q <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      to_q    <= to_d;
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end

  assign err       = err_q;
  assign retry_cnt = retry_q;
`else
  assign err       = 1'b0;
  assign retry_cnt = 3'd0;
`endif

  assign ddrphy_rst_req = req_q;
  assign done           = done_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_ipsl_ddrphy_rst_req_gen.sv
// Bench for ipsl_ddrphy_rst_req_gen: directed scenarios with literal expectations plus
// randomized start/ack/reset traffic compared every cycle against a timestamp-based model.
module tb_ipsl_ddrphy_rst_req_gen;

  localparam int L  = 4;
  localparam int T  = 16;
  localparam int MR = 3;
`ifdef DDRPHY_RST_REQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int PH_IDLE       = 0;
  localparam int PH_HIGH       = 1;
  localparam int PH_LOW_RETRY  = 2;
  localparam int PH_LOW_FINISH = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req_start;
  logic       ddrphy_rst_ack;
  logic       ddrphy_rst_req;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] retry_cnt;

  int checks   = 0;
  int failures = 0;
  int rises    = 0;
  logic prev_req = 1'b0;

  ipsl_ddrphy_rst_req_gen #(
    .TIMEOUT_CLK(T),
    .MAX_RETRY  (MR),
    .REQ_LOW_CLK(L)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_start     (req_start),
    .ddrphy_rst_ack(ddrphy_rst_ack),
    .ddrphy_rst_req(ddrphy_rst_req),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .retry_cnt     (retry_cnt)
  );

  always #5 clk = ~clk;

  // Model: edge counter plus timestamps of the last request rise and fall.
  typedef struct packed {
    int cyc;
    int t_fall;
    int t_rise;
    int ph;
    int retry;
    bit pend;
    bit req;
    bit done;
    bit err;
    bit busy;
  } mstate_t;

  mstate_t ms = '{cyc: 0, t_fall: 0, t_rise: 0, ph: PH_IDLE, retry: 0,
                  pend: 1'b0, req: 1'b0, done: 1'b0, err: 1'b0, busy: 1'b0};

  function automatic mstate_t model_reset(mstate_t s);
    mstate_t n;
    n        = '0;
    n.cyc    = s.cyc;
    n.t_fall = s.cyc;   // reset counts as a fresh falling edge
    n.ph     = PH_IDLE;
    return n;
  endfunction

  function automatic mstate_t model_next(mstate_t s, bit st, bit ak);
    mstate_t n;
    bit      low_ok;
    n      = s;
    n.cyc  = s.cyc + 1;
    n.done = 1'b0;
    n.pend = s.pend | st;
    low_ok = (n.cyc > s.t_fall + L);
    case (s.ph)
      PH_IDLE: begin
        if (n.pend && low_ok) begin
          n.ph     = PH_HIGH;
          n.t_rise = n.cyc;
          n.pend   = 1'b0;
          n.err    = 1'b0;
          n.retry  = 0;
        end
      end
      PH_HIGH: begin
        if (ak) begin
          n.done   = 1'b1;
          n.t_fall = n.cyc;
          n.ph     = PH_LOW_FINISH;
        end else if (TO_EN && (n.cyc - s.t_rise == T)) begin
          n.t_fall = n.cyc;
          if (s.retry < MR) begin
            n.retry = s.retry + 1;
            n.ph    = PH_LOW_RETRY;
          end else begin
            n.err = 1'b1;
            n.ph  = PH_LOW_FINISH;
          end
        end
      end
      PH_LOW_RETRY: begin
        if (low_ok) begin
          n.ph     = PH_HIGH;
          n.t_rise = n.cyc;
        end
      end
      default: begin
        if (low_ok) n.ph = PH_IDLE;
      end
    endcase
    n.req  = (n.ph == PH_HIGH);
    n.busy = (n.ph != PH_IDLE) || n.pend;
    return n;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) ms <= model_reset(ms);
    else       ms <= model_next(ms, req_start, ddrphy_rst_ack);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_req",   int'(ddrphy_rst_req), int'(ms.req));
    chk("model_done",  int'(done),           int'(ms.done));
    chk("model_busy",  int'(busy),           int'(ms.busy));
    chk("model_err",   int'(err),            int'(ms.err));
    chk("model_retry", int'(retry_cnt),      ms.retry);
    if (ddrphy_rst_req && !prev_req) rises <= rises + 1;
    prev_req <= ddrphy_rst_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int rb;
  int ack_div;

  initial begin
    rstn = 1'b0;
    req_start = 1'b0;
    ddrphy_rst_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",   int'(ddrphy_rst_req), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_err",   int'(err), 0);
    chk("rst_retry", int'(retry_cnt), 0);

    // post-reset start: request honours the low time
    rstn = 1'b1;
    req_start = 1'b1;
    tick();                                   // e0
    req_start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    repeat (3) tick();                        // e3
    chk("req_low_e3", int'(ddrphy_rst_req), 0);
    tick();                                   // e4
    chk("req_rise_e4", int'(ddrphy_rst_req), 1);
    repeat (8) tick();                        // e12
    ddrphy_rst_ack = 1'b1;
    tick();                                   // e13
    ddrphy_rst_ack = 1'b0;
    chk("done_after_ack", int'(done), 1);
    chk("req_fall_ack", int'(ddrphy_rst_req), 0);
    tick();                                   // e14
    chk("done_one_cycle", int'(done), 0);

    // spurious acks in GAP and IDLE
    ddrphy_rst_ack = 1'b1;
    tick();                                   // e15
    ddrphy_rst_ack = 1'b0;
    chk("gap_ack_no_done", int'(done), 0);
    repeat (2) tick();                        // e17
    chk("busy_in_gap", int'(busy), 1);
    tick();                                   // e18
    chk("busy_fall_idle", int'(busy), 0);
    ddrphy_rst_ack = 1'b1;
    tick();                                   // e19
    ddrphy_rst_ack = 1'b0;
    chk("idle_ack_no_done", int'(done), 0);
    chk("idle_ack_no_busy", int'(busy), 0);

    // back-to-back starts: two in REQ, one in GAP -> exactly one more sequence
    rb = rises;
    req_start = 1'b1;
    tick();                                   // e20
    req_start = 1'b0;
    chk("start_latency", int'(ddrphy_rst_req), 1);
    tick();
    req_start = 1'b1;
    tick();                                   // e22
    req_start = 1'b0;
    tick();
    req_start = 1'b1;
    tick();                                   // e24
    req_start = 1'b0;
    tick();
    ddrphy_rst_ack = 1'b1;
    tick();                                   // e26
    ddrphy_rst_ack = 1'b0;
    chk("b2b_done", int'(done), 1);
    tick();
    req_start = 1'b1;
    tick();                                   // e28
    req_start = 1'b0;
    repeat (3) tick();                        // e31
    chk("b2b_low_e31", int'(ddrphy_rst_req), 0);
    chk("b2b_pending_busy", int'(busy), 1);
    tick();                                   // e32
    chk("b2b_rise_e32", int'(ddrphy_rst_req), 1);
    ddrphy_rst_ack = 1'b1;
    tick();
    ddrphy_rst_ack = 1'b0;
    repeat (12) tick();
    chk("b2b_idle", int'(busy), 0);
    chk("b2b_rises", rises - rb, 2);

    // asynchronous reset while the request is high
    req_start = 1'b1;
    tick();
    req_start = 1'b0;
    repeat (2) tick();
    #2 rstn = 1'b0;
    #1;
    chk("arst_req_drop", int'(ddrphy_rst_req), 0);
    chk("arst_busy_drop", int'(busy), 0);
    @(posedge clk);
    #3 rstn = 1'b1;
    tick();
    req_start = 1'b1;
    tick();                                   // E1
    req_start = 1'b0;
    repeat (8) tick();
    ddrphy_rst_ack = 1'b1;
    tick();                                   // E10
    ddrphy_rst_ack = 1'b0;
    chk("arst_clean_done", int'(done), 1);
    chk("arst_clean_err", int'(err), 0);
    repeat (10) tick();

`ifdef DDRPHY_RST_REQ_TIMEOUT_EN
    // no responder: four 16-cycle pulses, then err
    rb = rises;
    req_start = 1'b1;
    tick();                                   // R0
    req_start = 1'b0;
    repeat (79) tick();                       // R0+79
    chk("to_err_set", int'(err), 1);
    chk("to_retry_max", int'(retry_cnt), 3);
    chk("to_req_low", int'(ddrphy_rst_req), 0);
    repeat (4) tick();
    chk("to_busy_gap", int'(busy), 1);
    tick();                                   // R0+84
    chk("to_busy_idle", int'(busy), 0);
    chk("to_pulse_count", rises - rb, 4);

    // ack on the last timeout cycle of the final retry
    req_start = 1'b1;
    tick();                                   // R0
    req_start = 1'b0;
    chk("to_err_cleared", int'(err), 0);
    repeat (78) tick();                       // R0+78
    ddrphy_rst_ack = 1'b1;
    tick();                                   // R0+79
    ddrphy_rst_ack = 1'b0;
    chk("to_ack_wins_done", int'(done), 1);
    chk("to_ack_wins_err", int'(err), 0);
    chk("to_ack_wins_retry", int'(retry_cnt), 3);
    repeat (10) tick();
`endif

    // randomized traffic
    ack_div = 4;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ((i % 500) == 0) ack_div = ($urandom_range(0, 1) == 0) ? 4 : 30;
      req_start      = ($urandom_range(0, 15) == 0);
      ddrphy_rst_ack = ($urandom_range(0, ack_div - 1) == 0);
      if ($urandom_range(0, 699) == 0) begin
        req_start      = 1'b0;
        ddrphy_rst_ack = 1'b0;
        #2 rstn = 1'b0;
        @(posedge clk);
        #3 rstn = 1'b1;
      end
    end
    req_start      = 1'b0;
    ddrphy_rst_ack = 1'b0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
